// File: rtl/alu_seq_mdu.sv
// alu_seq_mdu: registered execute-stage ALU with iterative RV64M multiply/divide.
//
// Single-cycle integer ops (ADD..AND, illegal codes, divide special cases)
// produce a result one cycle after acceptance. MUL/MULH/MULHSU/MULHU use a
// radix-2 shift-add on magnitudes; DIV/DIVU/REM/REMU use a restoring radix-2
// divider on magnitudes. Both need EW+1 cycles, where EW is 32 for *W ops and
// DATA_WIDTH otherwise.
//
// Ports:
//   clk        rising-edge clock
//   rst        asynchronous active-high reset
//   flush      abort the in-flight op and drop any held result
//   in_valid   request valid        / in_ready   request can be accepted
//   operand_a  source A             / operand_b  source B
//   alu_op     5-bit operation code / word_op    32-bit *W variant
//   out_valid  result valid         / out_ready  consumer takes result
//   result     registered result    / zero_flag  registered (result == 0)
//   busy       a multi-cycle op is in progress
module alu_seq_mdu #(
  parameter int DATA_WIDTH = 64,
  parameter int SHAMT_W    = $clog2(DATA_WIDTH)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] operand_a,
  input  logic [DATA_WIDTH-1:0] operand_b,
  input  logic [4:0]            alu_op,
  input  logic                  word_op,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] result,
  output logic                  zero_flag,
  output logic                  busy
);

  localparam int DW    = DATA_WIDTH;
  localparam int CNT_W = $clog2(DATA_WIDTH) + 1;

  localparam logic [4:0] OP_ADD  = 5'd0,  OP_SUB    = 5'd1,  OP_SLL   = 5'd2;
  localparam logic [4:0] OP_SLT  = 5'd3,  OP_SLTU   = 5'd4,  OP_XOR   = 5'd5;
  localparam logic [4:0] OP_SRL  = 5'd6,  OP_SRA    = 5'd7,  OP_OR    = 5'd8;
  localparam logic [4:0] OP_AND  = 5'd9,  OP_MUL    = 5'd10, OP_MULH  = 5'd11;
  localparam logic [4:0] OP_MULHSU = 5'd12, OP_MULHU = 5'd13, OP_DIV  = 5'd14;
  localparam logic [4:0] OP_DIVU = 5'd15, OP_REM    = 5'd16, OP_REMU  = 5'd17;

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV} state_t;

  function automatic logic [DW-1:0] sext32(input logic [DW-1:0] x);
    return DW'($signed(x[31:0]));
  endfunction

  function automatic logic [DW-1:0] zext32(input logic [DW-1:0] x);
    return DW'(x[31:0]);
  endfunction

  state_t             state_reg;
  logic [4:0]         op_reg;
  logic               word_reg;
  logic               neg_p_reg;   // product / quotient must be negated
  logic               neg_r_reg;   // remainder must be negated
  logic [CNT_W-1:0]   count_reg;
  logic [2*DW-1:0]    prod_reg;
  logic [2*DW-1:0]    mcand_reg;
  logic [DW-1:0]      mplier_reg;
  logic [DW-1:0]      quot_reg;
  logic [DW-1:0]      rem_reg;
  logic [DW-1:0]      divisor_reg;

  // ---------------- request decode ----------------
  logic               accept, word_capable, is_word, sgn_a, sgn_b;
  logic               is_mul, is_divgrp, div_zero, div_ovf;
  logic [DW-1:0]      a_ext, b_ext, mag_a, mag_b, min_ext;
  logic               neg_a, neg_b;
  logic [SHAMT_W-1:0] shamt;

  assign in_ready = (state_reg == S_IDLE) && (!out_valid || out_ready) && !flush;
  assign accept   = in_valid && in_ready;
  assign busy     = (state_reg != S_IDLE);

  always_comb begin
    word_capable = (alu_op == OP_ADD) || (alu_op == OP_SUB) || (alu_op == OP_SLL) ||
                   (alu_op == OP_SRL) || (alu_op == OP_SRA) || (alu_op == OP_MUL) ||
                   (alu_op >= OP_DIV && alu_op <= OP_REMU);
    is_word   = (DW == 64) && word_op && word_capable;
    is_mul    = (alu_op >= OP_MUL) && (alu_op <= OP_MULHU);
    is_divgrp = (alu_op >= OP_DIV) && (alu_op <= OP_REMU);
    sgn_a     = (alu_op == OP_MULH) || (alu_op == OP_MULHSU) ||
                (alu_op == OP_DIV)  || (alu_op == OP_REM);
    sgn_b     = (alu_op == OP_MULH) || (alu_op == OP_DIV) || (alu_op == OP_REM);
    // Operands reduced to EW bits and re-extended per signedness; MUL keeps
    // them unsigned since the low half of the product does not depend on sign.
    a_ext     = is_word ? (sgn_a ? sext32(operand_a) : zext32(operand_a)) : operand_a;
    b_ext     = is_word ? (sgn_b ? sext32(operand_b) : zext32(operand_b)) : operand_b;
    neg_a     = sgn_a && a_ext[DW-1];
    neg_b     = sgn_b && b_ext[DW-1];
    mag_a     = neg_a ? -a_ext : a_ext;
    mag_b     = neg_b ? -b_ext : b_ext;
    min_ext   = is_word ? sext32(DW'(32'h8000_0000)) : (DW'(1) << (DW - 1));
    div_zero  = (b_ext == '0);
    div_ovf   = sgn_b && (a_ext == min_ext) && (b_ext == '1);
    shamt     = is_word ? SHAMT_W'(operand_b[4:0]) : operand_b[SHAMT_W-1:0];
  end

  // ---------------- single-cycle results ----------------
  logic [DW-1:0]        quick_raw, quick_res, srl_src;
  logic signed [DW-1:0] sra_src;

  always_comb begin
    srl_src   = is_word ? zext32(operand_a) : operand_a;
    sra_src   = is_word ? sext32(operand_a) : operand_a;
    quick_raw = '0;
    case (alu_op)
      OP_ADD:  quick_raw = operand_a + operand_b;
      OP_SUB:  quick_raw = operand_a - operand_b;
      OP_SLL:  quick_raw = operand_a << shamt;
      OP_SLT:  quick_raw = DW'($signed(operand_a) < $signed(operand_b));
      OP_SLTU: quick_raw = DW'(operand_a < operand_b);
      OP_XOR:  quick_raw = operand_a ^ operand_b;
      OP_SRL:  quick_raw = srl_src >> shamt;
      OP_SRA:  quick_raw = sra_src >>> shamt;
      OP_OR:   quick_raw = operand_a | operand_b;
      OP_AND:  quick_raw = operand_a & operand_b;
      // Divide special cases; the regular divide path never reaches here.
      OP_DIV, OP_DIVU: quick_raw = div_zero ? '1 : min_ext;
      OP_REM, OP_REMU: quick_raw = div_zero ? a_ext : '0;
      default: quick_raw = '0;
    endcase
    quick_res = is_word ? sext32(quick_raw) : quick_raw;
  end

  // ---------------- multiply step ----------------
  logic [2*DW-1:0] prod_add, prod_fin;
  logic [DW-1:0]   mul_res;
  logic [CNT_W-1:0] ew_last;

  assign ew_last = word_reg ? CNT_W'(31) : CNT_W'(DW - 1);

  always_comb begin
    prod_add = prod_reg + (mplier_reg[0] ? mcand_reg : '0);
    prod_fin = neg_p_reg ? -prod_add : prod_add;
    if (op_reg == OP_MUL)
      mul_res = word_reg ? sext32(prod_fin[DW-1:0]) : prod_fin[DW-1:0];
    else
      mul_res = prod_fin[2*DW-1:DW];
  end

  // ---------------- divide step ----------------
  logic [DW:0]   div_shift, div_diff;
  logic          div_ge;
  logic [DW-1:0] rem_new, quot_new, q_fin, r_fin, div_raw, div_res;

  always_comb begin
    div_shift = {rem_reg, quot_reg[DW-1]};
    div_diff  = div_shift - {1'b0, divisor_reg};
    div_ge    = !div_diff[DW];  // no borrow: partial remainder >= divisor
    rem_new   = div_ge ? div_diff[DW-1:0] : div_shift[DW-1:0];
    quot_new  = {quot_reg[DW-2:0], div_ge};
    q_fin     = neg_p_reg ? -quot_new : quot_new;
    r_fin     = neg_r_reg ? -rem_new : rem_new;
    div_raw   = ((op_reg == OP_DIV) || (op_reg == OP_DIVU)) ? q_fin : r_fin;
    div_res   = word_reg ? sext32(div_raw) : div_raw;
  end

  // ---------------- state, iteration and output registers ----------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg   <= S_IDLE;
      out_valid   <= 1'b0;
      result      <= '0;
      zero_flag   <= 1'b0;
      op_reg      <= '0;
      word_reg    <= 1'b0;
      neg_p_reg   <= 1'b0;
      neg_r_reg   <= 1'b0;
      count_reg   <= '0;
      prod_reg    <= '0;
      mcand_reg   <= '0;
      mplier_reg  <= '0;
      quot_reg    <= '0;
      rem_reg     <= '0;
      divisor_reg <= '0;
    end else if (flush) begin
      // Flush wins over completion and over any request in the same cycle.
      state_reg <= S_IDLE;
      out_valid <= 1'b0;
      count_reg <= '0;
    end else begin
      if (out_valid && out_ready)
        out_valid <= 1'b0;
      case (state_reg)
        S_IDLE: begin
          if (accept) begin
            op_reg    <= alu_op;
            word_reg  <= is_word;
            count_reg <= '0;
            if (is_mul) begin
              state_reg  <= S_MUL;
              prod_reg   <= '0;
              mcand_reg  <= (2*DW)'(mag_a);
              mplier_reg <= mag_b;
              neg_p_reg  <= neg_a ^ neg_b;
            end else if (is_divgrp && !div_zero && !div_ovf) begin
              state_reg   <= S_DIV;
              rem_reg     <= '0;
              // Dividend is left-aligned so the MSB of the EW-bit value
              // enters the partial remainder first.
              quot_reg    <= is_word ? (mag_a << (DW - 32)) : mag_a;
              divisor_reg <= mag_b;
              neg_p_reg   <= neg_a ^ neg_b;
              neg_r_reg   <= neg_a;
            end else begin
              result    <= quick_res;
              zero_flag <= (quick_res == '0);
              out_valid <= 1'b1;
            end
          end
        end
        S_MUL: begin
          prod_reg   <= prod_add;
          mcand_reg  <= mcand_reg << 1;
          mplier_reg <= mplier_reg >> 1;
          if (count_reg == ew_last) begin
            state_reg <= S_IDLE;
            count_reg <= '0;
            result    <= mul_res;
            zero_flag <= (mul_res == '0);
            out_valid <= 1'b1;
          end else begin
            count_reg <= count_reg + 1'b1;
          end
        end
        S_DIV: begin
          rem_reg  <= rem_new;
          quot_reg <= quot_new;
          if (count_reg == ew_last) begin
            state_reg <= S_IDLE;
            count_reg <= '0;
            result    <= div_res;
            zero_flag <= (div_res == '0);
            out_valid <= 1'b1;
          end else begin
            count_reg <= count_reg + 1'b1;
          end
        end
        default: state_reg <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_seq_mdu.sv
// tb_alu_seq_mdu: directed self-checking bench for alu_seq_mdu (DATA_WIDTH=64).
// Inputs change on the falling edge; outputs are sampled on the falling edge.
module tb_alu_seq_mdu;

  localparam logic [4:0] ADD = 5'd0,  SUB = 5'd1,  SLL = 5'd2,  SLT = 5'd3;
  localparam logic [4:0] SLTU = 5'd4, XOR = 5'd5,  SRL = 5'd6,  SRA = 5'd7;
  localparam logic [4:0] AND = 5'd9,  MUL = 5'd10, MULH = 5'd11;
  localparam logic [4:0] MULHSU = 5'd12, MULHU = 5'd13, DIV = 5'd14;
  localparam logic [4:0] DIVU = 5'd15, REM = 5'd16, REMW_OP = 5'd16;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [63:0] operand_a = '0;
  logic [63:0] operand_b = '0;
  logic [4:0]  alu_op = '0;
  logic        word_op = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [63:0] result;
  logic        zero_flag;
  logic        busy;

  int total = 0;
  int bad   = 0;

  alu_seq_mdu #(.DATA_WIDTH(64)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .operand_a(operand_a), .operand_b(operand_b),
    .alu_op(alu_op), .word_op(word_op),
    .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .zero_flag(zero_flag), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got=%h want=%h", tag, got, want);
    end
  endtask

  // Issue one request, wait for its result and check value, flag, latency and busy.
  task automatic run_op(input string tag, input logic [4:0] op, input logic w,
                        input logic [63:0] a, input logic [63:0] b,
                        input logic [63:0] want, input int want_lat);
    int lat;
    int busy_bad;
    @(negedge clk);
    check({tag, ".rdy"}, 64'(in_ready), 64'd1);
    alu_op = op; word_op = w; operand_a = a; operand_b = b; in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    lat = 0;
    busy_bad = 0;
    do begin
      @(negedge clk);
      lat++;
      if (!out_valid && !busy) busy_bad++;
    end while (!out_valid && lat < 200);
    if (busy) busy_bad++;
    $display("op %s a=%h b=%h w=%0d result=%h zf=%0d lat=%0d",
             tag, a, b, w, result, zero_flag, lat);
    check({tag, ".lat"}, 64'(lat), 64'(want_lat));
    check({tag, ".res"}, result, want);
    check({tag, ".zf"}, 64'(zero_flag), 64'(want == 64'd0));
    check({tag, ".busy"}, 64'(busy_bad), 64'd0);
  endtask

  initial begin
    int seen;
    // ---------- reset ----------
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst.valid", 64'(out_valid), 64'd0);
    check("rst.result", result, 64'd0);
    check("rst.zf", 64'(zero_flag), 64'd0);
    check("rst.busy", 64'(busy), 64'd0);
    rst = 1'b0;
    @(negedge clk);
    check("rst.rdy", 64'(in_ready), 64'd1);

    // ---------- single-cycle ops ----------
    run_op("add",   ADD,  1'b0, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 64'h8000_0000_0000_0000, 1);
    run_op("addw",  ADD,  1'b1, 64'h0000_0000_7FFF_FFFF, 64'd1, 64'hFFFF_FFFF_8000_0000, 1);
    run_op("sraw",  SRA,  1'b1, 64'h0000_0000_8000_0000, 64'd4, 64'hFFFF_FFFF_F800_0000, 1);
    run_op("sllw",  SLL,  1'b1, 64'd1, 64'd31, 64'hFFFF_FFFF_8000_0000, 1);
    run_op("srlw",  SRL,  1'b1, 64'hFFFF_FFFF_8000_0000, 64'd4, 64'h0000_0000_0800_0000, 1);
    run_op("sll",   SLL,  1'b0, 64'h0000_0000_0000_0003, 64'd65, 64'd6, 1);
    run_op("srl",   SRL,  1'b0, 64'h8000_0000_0000_0000, 64'd63, 64'd1, 1);
    run_op("slt",   SLT,  1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 64'd1, 1);
    run_op("sltu",  SLTU, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 64'd0, 1);
    run_op("illeg", 5'd20, 1'b0, 64'd5, 64'd6, 64'd0, 1);

    // ---------- multiply ----------
    run_op("mulh",   MULH,   1'b0, '1, '1, 64'd0, 65);
    run_op("mulhu",  MULHU,  1'b0, '1, '1, 64'hFFFF_FFFF_FFFF_FFFE, 65);
    run_op("mulhsu", MULHSU, 1'b0, '1, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF, 65);
    run_op("mul",    MUL,    1'b0, 64'd3, 64'hFFFF_FFFF_FFFF_FFFB, 64'hFFFF_FFFF_FFFF_FFF1, 65);
    run_op("mulw",   MUL,    1'b1, 64'h1_0000, 64'h1_0000, 64'd0, 33);

    // ---------- divide ----------
    run_op("div",    DIV,  1'b0, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFD, 65);
    run_op("rem",    REM,  1'b0, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF, 65);
    run_op("divw",   DIV,  1'b1, 64'h0000_0000_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFD, 33);
    run_op("divuw",  DIVU, 1'b1, 64'h0000_0000_FFFF_FFFF, 64'd1, 64'hFFFF_FFFF_FFFF_FFFF, 33);
    run_op("divu0",  DIVU, 1'b0, 64'd123, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 1);
    run_op("divovf", DIV,  1'b0, 64'h8000_0000_0000_0000, '1, 64'h8000_0000_0000_0000, 1);
    run_op("remw0",  REMW_OP, 1'b1, 64'd5, 64'd0, 64'd5, 1);

    // ---------- backpressure ----------
    @(negedge clk);
    out_ready = 1'b0;
    run_op("xor_bp", XOR, 1'b0, 64'hF0, 64'hFF, 64'h0F, 1);
    alu_op = SUB; word_op = 1'b0; operand_a = 64'd10; operand_b = 64'd3; in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("bp.valid", 64'(out_valid), 64'd1);
      check("bp.hold", result, 64'h0F);
      check("bp.rdy", 64'(in_ready), 64'd0);
    end
    @(negedge clk);
    out_ready = 1'b1;
    #1 check("bp.rdy_up", 64'(in_ready), 64'd1);
    @(posedge clk);
    #1 in_valid = 1'b0;
    @(negedge clk);
    $display("op sub_b2b result=%h valid=%0d", result, out_valid);
    check("b2b.valid", 64'(out_valid), 64'd1);
    check("b2b.res", result, 64'd7);

    // ---------- flush mid-divide ----------
    @(negedge clk);
    alu_op = DIVU; word_op = 1'b0; operand_a = 64'd100; operand_b = 64'd7; in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    repeat (9) @(posedge clk);
    @(negedge clk);
    check("fl.busy_pre", 64'(busy), 64'd1);
    flush = 1'b1;
    @(posedge clk);
    #1 flush = 1'b0;
    @(negedge clk);
    check("fl.busy", 64'(busy), 64'd0);
    check("fl.valid", 64'(out_valid), 64'd0);
    seen = 0;
    for (int i = 0; i < 80; i++) begin
      @(negedge clk);
      if (out_valid) seen++;
    end
    $display("op divu_flush seen_valid=%0d", seen);
    check("fl.never", 64'(seen), 64'd0);

    // ---------- reset mid-multiply ----------
    @(negedge clk);
    alu_op = MUL; word_op = 1'b0; operand_a = 64'd9; operand_b = 64'd9; in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    repeat (20) @(posedge clk);
    @(negedge clk);
    check("rm.busy_pre", 64'(busy), 64'd1);
    rst = 1'b1;
    #1;
    check("rm.valid", 64'(out_valid), 64'd0);
    check("rm.result", result, 64'd0);
    check("rm.zf", 64'(zero_flag), 64'd0);
    check("rm.busy", 64'(busy), 64'd0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    seen = 0;
    for (int i = 0; i < 70; i++) begin
      @(negedge clk);
      if (out_valid) seen++;
    end
    $display("op mul_reset seen_valid=%0d", seen);
    check("rm.stale", 64'(seen), 64'd0);
    run_op("and", AND, 1'b0, 64'hFF00, 64'h0FF0, 64'h0F00, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
